// File: rtl/mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// mem_responder_pkg
// Shared definitions for the memory responder and its neighbours (PC, MAR/MDR,
// fetch FSM): default bus widths, handshake state encodings and RW constants.
// No ports; import with "import mem_responder_pkg::*;".
// ---------------------------------------------------------------------------
package mem_responder_pkg;

  // Default widths shared by every block on the memory path
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 8;
  localparam int ADDR_BUS_W = 16;

  // Latency counter width; supports access latencies of 1..15 cycles
  localparam int CNT_W = 4;

  // RW line encoding as driven by the fetch/execute FSMs
  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  // Responder handshake states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_t;

  // Counter preload: the counter reaches zero on the edge where the access
  // completes, so it starts one below the latency.
  function automatic logic [CNT_W-1:0] latency_load(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// ---------------------------------------------------------------------------
// mem_responder_if
// Request/response bundle between the MAR/MDR path (master) and the memory
// responder (slave).
//   memEN  : request strobe, held by the master until MFC is seen
//   RW     : 1 = read, 0 = write
//   addr   : full MAR address (the responder uses only its low bits)
//   wdata  : write data from MDR
//   rdata  : read data back to MDR
//   MFC    : memory function complete
//   busy   : responder is working on or finishing a transaction
// ---------------------------------------------------------------------------
interface mem_responder_if
  import mem_responder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();

  logic                  memEN;
  logic                  RW;
  logic [ADDR_BUS_W-1:0] addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W-1:0]     rdata;
  logic                  MFC;
  logic                  busy;

  modport master (
    output memEN,
    output RW,
    output addr,
    output wdata,
    input  rdata,
    input  MFC,
    input  busy
  );

  modport slave (
    input  memEN,
    input  RW,
    input  addr,
    input  wdata,
    output rdata,
    output MFC,
    output busy
  );

endinterface

// File: rtl/mem_responder_mem_array.sv
// ---------------------------------------------------------------------------
// mem_array
// Single-port DEPTH x DATA_W word storage, synchronous write and registered
// read. Contents are never reset; only the read register is.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset of the read register
//   we   : write enable, din stored at addr on the rising edge
//   re   : read enable, dout loads the word at addr on the rising edge
//   addr : word address
//   din  : write data
//   dout : registered read data, holds its value while re is low
// ---------------------------------------------------------------------------
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage write port; kept out of the reset domain so contents survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
  end

  // Registered read port; holds the last read word until the next read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout <= '0;
    end else if (re) begin
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Memory-side responder for the memEN/RW/MFC handshake. Accepts a request in
// IDLE, waits LATENCY cycles, performs the read or write on the internal
// array, then raises MFC and holds it until the initiator drops memEN.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset (aborts any pending access)
//   bus : mem_responder_if slave modport (memEN, RW, addr, wdata in;
//         rdata, MFC, busy out)
// ---------------------------------------------------------------------------
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LATENCY = 3
) (
  input  logic             clk,
  input  logic             rst,
  mem_responder_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = latency_load(LATENCY);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic               rw_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               commit;
  logic               arr_we;
  logic               arr_re;
  logic               mfc;
  logic               busy;
  logic [DATA_W-1:0]  arr_dout;

  // Upper MAR bits wrap onto the implemented array and are deliberately dropped
  logic addr_unused;
  assign addr_unused = ^bus.addr[ADDR_BUS_W-1:ADDR_W];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request latches and latency counter; the request is captured only on
  // acceptance so later changes on the bus cannot disturb the access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      rw_q    <= MEM_WRITE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && bus.memEN) begin
      cnt     <= CNT_LOAD;
      rw_q    <= bus.RW;
      addr_q  <= bus.addr[ADDR_W-1:0];
      wdata_q <= bus.wdata;
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Next-state logic. Dropping memEN during WAIT does not cancel the access;
  // DONE then sees memEN low and leaves after a single MFC cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.memEN) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (!bus.memEN) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs. MFC is a pure function of the registered state, so it rises on
  // the completion edge together with the array's registered read data and
  // there is no combinational path from the bus inputs to any output.
  always_comb begin
    commit = 1'b0;
    arr_we = 1'b0;
    arr_re = 1'b0;
    mfc    = 1'b0;
    busy   = 1'b0;
    commit = (state == WAIT) && (cnt == '0);
    arr_we = commit && (rw_q == MEM_WRITE);
    arr_re = commit && (rw_q == MEM_READ);
    mfc    = (state == DONE);
    busy   = (state != IDLE);
  end

  mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem_array (
    .clk  (clk),
    .rst  (rst),
    .we   (arr_we),
    .re   (arr_re),
    .addr (addr_q),
    .din  (wdata_q),
    .dout (arr_dout)
  );

  assign bus.rdata = arr_dout;
  assign bus.MFC   = mfc;
  assign bus.busy  = busy;

endmodule
